// File: rtl/vending_machine_gen_if.sv
// Signal bundle between the vending controller and its surroundings:
// one-pulsed button/keyboard inputs in, display and dispenser signals out.
interface vending_machine_gen_if #(
   parameter int NUM_ITEMS = 4,
   parameter int NUM_COINS = 3,
   parameter int CREDIT_W  = 8
);
   localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

   logic                  tick;
   logic [NUM_COINS-1:0]  coin_in;
   logic [NUM_ITEMS-1:0]  select;
   logic                  cancel;
   logic                  restock;
   logic [CREDIT_W-1:0]   credit;
   logic [NUM_ITEMS-1:0]  affordable;
   logic [NUM_ITEMS-1:0]  sold_out;
   logic                  vend_valid;
   logic [ITEM_W-1:0]     vend_item;
   logic                  coin_out_valid;
   logic [NUM_COINS-1:0]  coin_out_sel;
   logic                  coin_reject;
   logic                  busy;

   modport master (
      output tick, coin_in, select, cancel, restock,
      input  credit, affordable, sold_out, vend_valid, vend_item,
             coin_out_valid, coin_out_sel, coin_reject, busy
   );

   modport slave (
      input  tick, coin_in, select, cancel, restock,
      output credit, affordable, sold_out, vend_valid, vend_item,
             coin_out_valid, coin_out_sel, coin_reject, busy
   );
endinterface

// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: per-item price and stock, capped credit,
// and greedy coin-by-coin change return paced by an external tick.
module vending_machine_gen #(
   parameter int                            NUM_ITEMS  = 4,
   parameter int                            NUM_COINS  = 3,
   parameter int                            CREDIT_W   = 8,
   parameter int                            MAX_CREDIT = 99,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd60, 8'd30, 8'd25, 8'd20},
   parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALS  = {8'd50, 8'd10, 8'd5},
   parameter int                            STOCK_W    = 4,
   parameter int                            STOCK_INIT = 5
) (
   input  logic                clk,
   input  logic                rst,
   vending_machine_gen_if.slave bus
);
   localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam logic [CREDIT_W:0]  MAX_SUM    = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);

   typedef enum logic {S_IDLE, S_RETURN} state_t;

   state_t               state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
   logic                 vend_valid_q, vend_valid_d;
   logic [ITEM_W-1:0]    vend_item_q, vend_item_d;
   logic                 coin_out_valid_q, coin_out_valid_d;
   logic [NUM_COINS-1:0] coin_out_sel_q, coin_out_sel_d;
   logic                 coin_reject_q, coin_reject_d;

   logic [NUM_ITEMS-1:0] affordable;
   logic [CREDIT_W:0]    sum;
   logic                 coinHit, selHit, retHit;
   int                   coinIdx, selIdx, retIdx;

   always_comb begin
      affordable   = '0;
      bus.sold_out = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         bus.sold_out[i] = (stock_q[i] == '0);
         affordable[i]   = (credit_q >= PRICES[i*CREDIT_W +: CREDIT_W]) &&
                           (stock_q[i] != '0) && (state_q == S_IDLE);
      end
   end

   assign bus.affordable     = affordable;
   assign bus.credit         = credit_q;
   assign bus.vend_valid     = vend_valid_q;
   assign bus.vend_item      = vend_item_q;
   assign bus.coin_out_valid = coin_out_valid_q;
   assign bus.coin_out_sel   = coin_out_sel_q;
   assign bus.coin_reject    = coin_reject_q;
   assign bus.busy           = (state_q == S_RETURN);

   always_comb begin
      state_d          = state_q;
      credit_d         = credit_q;
      stock_d          = stock_q;
      vend_valid_d     = 1'b0;
      vend_item_d      = vend_item_q;
      coin_out_valid_d = 1'b0;
      coin_out_sel_d   = '0;
      coin_reject_d    = 1'b0;
      coinHit = 1'b0;
      coinIdx = 0;
      selHit  = 1'b0;
      selIdx  = 0;
      retHit  = 1'b0;
      retIdx  = 0;

      // Lowest index wins for inserts and selections; the change coin is the
      // largest denomination that still fits into the remaining credit.
      for (int j = NUM_COINS-1; j >= 0; j--) begin
         if (bus.coin_in[j]) begin
            coinHit = 1'b1;
            coinIdx = j;
         end
      end
      for (int i = NUM_ITEMS-1; i >= 0; i--) begin
         if (bus.select[i]) begin
            selHit = 1'b1;
            selIdx = i;
         end
      end
      for (int j = 0; j < NUM_COINS; j++) begin
         if (COIN_VALS[j*CREDIT_W +: CREDIT_W] <= credit_q) begin
            retHit = 1'b1;
            retIdx = j;
         end
      end

      sum = {1'b0, credit_q} + {1'b0, COIN_VALS[coinIdx*CREDIT_W +: CREDIT_W]};

      case (state_q)
         S_IDLE: begin
            if (coinHit) begin
               if (sum <= MAX_SUM) begin
                  credit_d = sum[CREDIT_W-1:0];
               end else begin
                  coin_reject_d = 1'b1;
               end
            end else if (selHit) begin
               if (affordable[selIdx]) begin
                  credit_d        = credit_q - PRICES[selIdx*CREDIT_W +: CREDIT_W];
                  stock_d[selIdx] = stock_q[selIdx] - 1'b1;
                  vend_valid_d    = 1'b1;
                  vend_item_d     = ITEM_W'(selIdx);
                  state_d         = (credit_d != '0) ? S_RETURN : S_IDLE;
               end
            end else if (bus.cancel) begin
               if (credit_q != '0) begin
                  state_d = S_RETURN;
               end
            end else if (bus.restock) begin
               for (int i = 0; i < NUM_ITEMS; i++) begin
                  stock_d[i] = STOCK_LOAD;
               end
            end
         end
         S_RETURN: begin
            if (bus.tick) begin
               if (retHit) begin
                  credit_d               = credit_q - COIN_VALS[retIdx*CREDIT_W +: CREDIT_W];
                  coin_out_valid_d       = 1'b1;
                  coin_out_sel_d[retIdx] = 1'b1;
               end else begin
                  credit_d = '0;
               end
               if (credit_d == '0) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q          <= S_IDLE;
         credit_q         <= '0;
         vend_valid_q     <= 1'b0;
         vend_item_q      <= '0;
         coin_out_valid_q <= 1'b0;
         coin_out_sel_q   <= '0;
         coin_reject_q    <= 1'b0;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_q[i] <= STOCK_LOAD;
         end
      end else begin
         state_q          <= state_d;
         credit_q         <= credit_d;
         vend_valid_q     <= vend_valid_d;
         vend_item_q      <= vend_item_d;
         coin_out_valid_q <= coin_out_valid_d;
         coin_out_sel_q   <= coin_out_sel_d;
         coin_reject_q    <= coin_reject_d;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_q[i] <= stock_d[i];
         end
      end
   end
endmodule

// File: doc/vending_machine_gen.md
Name: vending_machine_gen

Overview:
Parametrised vending controller: N items with per-item price and stock, M coin denominations with per-coin values, capped credit, and greedy coin-by-coin change return paced by an external tick. It sits between the debounced/one-pulsed button and keyboard inputs and the credit display driver. It generalises the fixed 4-drink, 3-coin machine. New behaviour over that machine:
- stock tracking and sold-out flags
- rejection of over-cap coins
- denomination-aware change output

Parameters:
NUM_ITEMS, 4, number of selectable items
NUM_COINS, 3, number of accepted coin denominations
CREDIT_W, 8, credit register width
MAX_CREDIT, 99, credit ceiling; must be < 2^CREDIT_W
PRICES, {8'd60,8'd30,8'd25,8'd20}, packed CREDIT_W-bit prices; item i = slice i
COIN_VALS, {8'd50,8'd10,8'd5}, packed CREDIT_W-bit coin values; strictly ascending with index
STOCK_W, 4, per-item stock counter width
STOCK_INIT, 5, stock loaded at reset and on restock

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
tick  in  1  one-cycle pacing pulse (1 Hz in system), used only in RETURN
coin_in  in  NUM_COINS  one-cycle insert pulses, bit j = denomination j
select  in  NUM_ITEMS  one-cycle purchase pulses, bit i = item i
cancel  in  1  one-cycle cancel pulse
restock  in  1  one-cycle pulse, reloads all stock (IDLE only)
credit  out  CREDIT_W  current credit (registered)
affordable  out  NUM_ITEMS  bit i = credit>=PRICES[i] && stock[i]!=0 && state==IDLE
sold_out  out  NUM_ITEMS  bit i = stock[i]==0
vend_valid  out  1  one-cycle pulse: item dispensed
vend_item  out  clog2(NUM_ITEMS)  index of dispensed item, valid with vend_valid
coin_out_valid  out  1  one-cycle pulse: one change coin dispensed
coin_out_sel  out  NUM_COINS  one-hot denomination of dispensed coin
coin_reject  out  1  one-cycle pulse: inserted coin refused
busy  out  1  high in RETURN

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, credit=0, all stock=STOCK_INIT, all pulse outputs 0, coin_out_sel=0, vend_item=0.
- All outputs are registered except affordable and sold_out, which are decoded from registers.
- States: IDLE, RETURN.
- IDLE, one event per cycle. Priority: coin_in > select > cancel > restock. Lower index wins within coin_in and within select; other events that cycle are dropped.
  - Coin j: if credit+COIN_VALS[j] <= MAX_CREDIT, then credit += value. Otherwise credit is unchanged and coin_reject pulses next cycle. The sum is computed at CREDIT_W+1 bits, with no wrap.
  - Select i with affordable[i]: credit -= PRICES[i], stock[i] -= 1, and vend_valid/vend_item pulse next cycle. Next state is RETURN if the new credit is > 0, else IDLE.
  - Select i not affordable: no effect.
  - Cancel with credit > 0: go to RETURN, credit unchanged. Cancel with credit == 0: no-op.
  - Restock: all stock = STOCK_INIT.
- RETURN: coin_in, select, cancel and restock are ignored; coins are not rejected.
  - On each tick: pick the largest j with COIN_VALS[j] <= credit. Credit -= value, coin_out_valid pulses and coin_out_sel = onehot(j), both registered the cycle after tick.
  - If no coin fits (credit < COIN_VALS[0]), credit := 0 and no coin pulse.
  - When the new credit == 0, next state is IDLE on the same edge.
  - No tick: hold.
- First change coin comes on the first tick after entering RETURN. A tick coincident with the entry edge is not consumed.
- Stock never underflows, because affordable requires stock != 0.
- Reset mid-RETURN: IDLE, credit 0, no further coin pulses, stock reloaded.

Test Plan:
1. Reset with rst=0 for 2 cycles -> credit=0, sold_out=0000, affordable=0000, busy=0, stock 5 each.
2. Insert coin_in=100 then 010 (50, then 10) -> credit=60, affordable=1111. Insert 100 again (60+50>99) -> coin_reject pulse, credit stays 60.
3. Credit 60, select[1] (price 25) -> vend_valid, vend_item=1, credit=35, busy=1. Then 4 ticks -> coin_out_sel 010,010,010,001, credit 25,15,5,0, then IDLE.
4. Credit 20, cancel -> busy. Tick -> coin_out_sel=010, credit 10. Tick -> 010, credit 0, IDLE. Cancel at credit 0 -> no state change.
5. Buy item 0 five times (insert 10+10 each) -> after the 5th, sold_out[0]=1 and affordable[0]=0 at credit 20. A further select[0] has no effect. restock -> sold_out[0]=0.
6. Same cycle coin_in=001 and select=0001 at credit 20 -> only the coin is taken (credit 25), no vend. During RETURN a coin_in is ignored: no credit change, no reject. rst=0 mid-RETURN -> credit 0, IDLE.
